// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - two-stage playfield/preview pixel renderer with line-clear flash FSM.
// Optional grid lines: define BOARD_RENDERER_GRID_EN.
module board_renderer #(
    parameter int CELL_PX      = 20,
    parameter int BOARD_COLS   = 10,
    parameter int BOARD_ROWS   = 20,
    parameter int BOARD_X0     = 220,
    parameter int BOARD_Y0     = 40,
    parameter int NEXT_X0      = 480,
    parameter int NEXT_Y0      = 40,
    parameter int FRAME_PX     = 20,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_BLINKS = 3,
    localparam int AW = $clog2(BOARD_COLS * BOARD_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  blank_n,
    input  logic [8:0]            row,
    input  logic [9:0]            column,
    input  logic                  frame_start,
    input  logic [2:0]            next_block,
    output logic [AW-1:0]         cell_addr,
    input  logic [2:0]            cell_data,
    input  logic                  flash_start,
    input  logic [BOARD_ROWS-1:0] flash_rows,
    output logic                  flash_busy,
    output logic                  flash_done,
    output logic                  board,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue
);

    localparam int RW  = (BOARD_ROWS > 1) ? $clog2(BOARD_ROWS) : 1;
    localparam int FCW = $clog2(FLASH_FRAMES + 1);
    localparam int TCW = $clog2(2 * FLASH_BLINKS + 1);
    localparam int BW  = BOARD_COLS * CELL_PX;
    localparam int BH  = BOARD_ROWS * CELL_PX;
    localparam int NW  = 6 * CELL_PX;
    localparam int NH  = 4 * CELL_PX;

    localparam logic [23:0] C_WHITE       = 24'hFFFFFF;
    localparam logic [23:0] C_LIGHT_GREY  = 24'hA0A0A0;
    localparam logic [23:0] C_DARK_GREY   = 24'h606060;
    localparam logic [23:0] C_PURPLE      = 24'hFF99FF;

    typedef enum logic [2:0] {RG_OTHER, RG_FRAME, RG_BOARD, RG_PREV, RG_PIECE} region_e;
    typedef enum logic [1:0] {S_IDLE, S_FLASH, S_DONE} state_e;

    function automatic logic [23:0] cell_rgb(input logic [2:0] t);
        case (t)
            3'd1:    return 24'h66B2FF;
            3'd2:    return 24'hFF3399;
            3'd3:    return 24'h7F00FF;
            3'd4:    return 24'hFFFF66;
            3'd5:    return 24'h66FF66;
            3'd6:    return 24'h990099;
            3'd7:    return 24'h99FFCC;
            default: return 24'hFFCCE5;
        endcase
    endfunction

    function automatic logic piece_hit(input logic [2:0] t, input int r, input int c);
        case (t)
            3'd7:    return (r == 1) && (c >= 1) && (c <= 4);
            3'd1:    return ((r == 1) && (c >= 1) && (c <= 3)) || ((r == 2) && (c == 2));
            3'd2:    return ((r == 1) || (r == 2)) && ((c == 2) || (c == 3));
            3'd3:    return ((r == 2) && (c >= 1) && (c <= 3)) || ((r == 1) && (c == 3));
            3'd4:    return ((r == 1) && (c >= 1) && (c <= 3)) || ((r == 2) && (c == 1));
            3'd5:    return ((r == 1) && ((c == 2) || (c == 3))) || ((r == 2) && ((c == 1) || (c == 2)));
            3'd6:    return ((r == 1) && ((c == 1) || (c == 2))) || ((r == 2) && ((c == 2) || (c == 3)));
            default: return 1'b0;
        endcase
    endfunction

    int      px, py, bx, by, nx, ny;
    logic    in_board, in_bring, in_next, in_nring;
    region_e region_d, region_q;
    logic [RW-1:0] cell_row_d, cell_row_q;
    logic          blank_q;
    logic [2:0]    next_q;
    logic [23:0]   rgb_d, rgb_q;
    logic          board_q;

    always_comb begin
        px = int'(column);
        py = int'(row);
        bx = px - BOARD_X0;
        by = py - BOARD_Y0;
        nx = px - NEXT_X0;
        ny = py - NEXT_Y0;
        in_board = (bx >= 0) && (bx < BW) && (by >= 0) && (by < BH);
        in_next  = (nx >= 0) && (nx < NW) && (ny >= 0) && (ny < NH);
        in_bring = (bx >= -FRAME_PX) && (bx < BW + FRAME_PX) && (by >= -FRAME_PX) && (by < BH + FRAME_PX);
        in_nring = (nx >= -FRAME_PX) && (nx < NW + FRAME_PX) && (ny >= -FRAME_PX) && (ny < NH + FRAME_PX);
        region_d   = RG_OTHER;
        cell_addr  = '0;
        cell_row_d = '0;
        if (in_board) begin
            region_d   = RG_BOARD;
            cell_addr  = AW'((by / CELL_PX) * BOARD_COLS + (bx / CELL_PX));
            cell_row_d = RW'(by / CELL_PX);
        end else if (in_bring || (in_nring && !in_next)) begin
            region_d = RG_FRAME;
        end else if (in_next) begin
            region_d = piece_hit(next_block, ny / CELL_PX, nx / CELL_PX) ? RG_PIECE : RG_PREV;
        end
    end

`ifdef BOARD_RENDERER_GRID_EN
    logic grid_d, grid_q;
    assign grid_d = in_board && (((bx % CELL_PX) == 0) || ((by % CELL_PX) == 0));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            region_q   <= RG_OTHER;
            cell_row_q <= '0;
            blank_q    <= 1'b0;
            next_q     <= '0;
`ifdef BOARD_RENDERER_GRID_EN
            grid_q     <= 1'b0;
`endif
        end else begin
            region_q   <= region_d;
            cell_row_q <= cell_row_d;
            blank_q    <= blank_n;
            next_q     <= next_block;
`ifdef BOARD_RENDERER_GRID_EN
            grid_q     <= grid_d;
`endif
        end
    end

    state_e                state_d, state_q;
    logic                  phase_d, phase_q;
    logic [BOARD_ROWS-1:0] mask_d, mask_q;
    logic [FCW-1:0]        frm_d, frm_q;
    logic [TCW-1:0]        tgl_d, tgl_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        mask_d     = mask_q;
        frm_d      = frm_q;
        tgl_d      = tgl_q;
        flash_busy = (state_q != S_IDLE);
        flash_done = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (flash_start) begin
                    mask_d  = flash_rows;
                    frm_d   = '0;
                    tgl_d   = '0;
                    phase_d = 1'b1;
                    state_d = S_FLASH;
                end
            end
            S_FLASH: begin
                if (frame_start) begin
                    if (frm_q == FCW'(FLASH_FRAMES - 1)) begin
                        frm_d   = '0;
                        phase_d = ~phase_q;
                        tgl_d   = tgl_q + 1'b1;
                        if (tgl_q == TCW'(2 * FLASH_BLINKS - 1)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        frm_d = frm_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                mask_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            mask_q  <= '0;
            frm_q   <= '0;
            tgl_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
            frm_q   <= frm_d;
            tgl_q   <= tgl_d;
        end
    end

    // Flash WHITE wins over both cell colour and grid lines.
    always_comb begin
        rgb_d = '0;
        if (blank_q) begin
            case (region_q)
                RG_BOARD: begin
                    if ((state_q == S_FLASH) && phase_q && mask_q[cell_row_q]) begin
                        rgb_d = C_WHITE;
                    end else begin
                        rgb_d = cell_rgb(cell_data);
`ifdef BOARD_RENDERER_GRID_EN
                        if (grid_q) rgb_d = C_DARK_GREY;
`endif
                    end
                end
                RG_FRAME: rgb_d = C_LIGHT_GREY;
                RG_PREV:  rgb_d = C_PURPLE;
                RG_PIECE: rgb_d = cell_rgb(next_q);
                default:  rgb_d = C_DARK_GREY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q   <= '0;
            board_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            board_q <= (region_q == RG_BOARD);
        end
    end

    assign red   = rgb_q[23:16];
    assign green = rgb_q[15:8];
    assign blue  = rgb_q[7:0];
    assign board = board_q;

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed vector table plus flash/reset sequences for board_renderer.
module tb_board_renderer;

    logic        clk;
    logic        rst;
    logic        blank_n;
    logic [8:0]  row;
    logic [9:0]  column;
    logic        frame_start;
    logic [2:0]  next_block;
    logic [7:0]  cell_addr;
    logic [2:0]  cell_data;
    logic        flash_start;
    logic [19:0] flash_rows;
    logic        flash_busy;
    logic        flash_done;
    logic        board;
    logic [7:0]  red, green, blue;

    int n_vec = 0;
    int n_fail = 0;

    board_renderer #(
        .FLASH_FRAMES(2),
        .FLASH_BLINKS(1)
    ) dut (
        .clk(clk), .rst(rst), .blank_n(blank_n), .row(row), .column(column),
        .frame_start(frame_start), .next_block(next_block), .cell_addr(cell_addr),
        .cell_data(cell_data), .flash_start(flash_start), .flash_rows(flash_rows),
        .flash_busy(flash_busy), .flash_done(flash_done), .board(board),
        .red(red), .green(green), .blue(blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] mem [256];
    always @(posedge clk) cell_data <= mem[cell_addr];

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        blank;
        logic [2:0]  nb;
        logic [7:0]  addr;
        logic [23:0] rgb;
        logic        brd;
        logic        chk_b;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_px(input logic [8:0] r, input logic [9:0] c, input logic b, input logic [2:0] nb);
        row = r;
        column = c;
        blank_n = b;
        next_block = nb;
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, red, green, blue};
    endfunction

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    int done_seen;

    initial begin
        vt[0]  = '{9'd40,  10'd220, 1'b1, 3'd0, 8'd0,   24'hFFCCE5, 1'b1, 1'b1};
        vt[1]  = '{9'd439, 10'd419, 1'b1, 3'd0, 8'd199, 24'h66FF66, 1'b1, 1'b1};
        vt[2]  = '{9'd100, 10'd300, 1'b1, 3'd0, 8'd34,  24'hFF3399, 1'b1, 1'b1};
        vt[3]  = '{9'd70,  10'd520, 1'b1, 3'd7, 8'd0,   24'h99FFCC, 1'b0, 1'b1};
        vt[4]  = '{9'd70,  10'd520, 1'b1, 3'd0, 8'd0,   24'hFF99FF, 1'b0, 1'b1};
        vt[5]  = '{9'd30,  10'd210, 1'b1, 3'd0, 8'd0,   24'hA0A0A0, 1'b0, 1'b1};
        vt[6]  = '{9'd0,   10'd0,   1'b1, 3'd0, 8'd0,   24'h606060, 1'b0, 1'b1};
        vt[7]  = '{9'd100, 10'd300, 1'b0, 3'd0, 8'd34,  24'h000000, 1'b1, 1'b0};
        vt[8]  = '{9'd30,  10'd470, 1'b1, 3'd0, 8'd0,   24'hA0A0A0, 1'b0, 1'b1};
        vt[9]  = '{9'd85,  10'd525, 1'b1, 3'd1, 8'd0,   24'h66B2FF, 1'b0, 1'b1};
        vt[10] = '{9'd65,  10'd545, 1'b1, 3'd3, 8'd0,   24'h7F00FF, 1'b0, 1'b1};
        vt[11] = '{9'd65,  10'd505, 1'b1, 3'd3, 8'd0,   24'hFF99FF, 1'b0, 1'b1};
        vt[12] = '{9'd85,  10'd545, 1'b1, 3'd6, 8'd0,   24'h990099, 1'b0, 1'b1};
        vt[13] = '{9'd65,  10'd525, 1'b1, 3'd2, 8'd0,   24'hFF3399, 1'b0, 1'b1};
        vt[14] = '{9'd85,  10'd505, 1'b1, 3'd4, 8'd0,   24'hFFFF66, 1'b0, 1'b1};
        vt[15] = '{9'd65,  10'd505, 1'b1, 3'd5, 8'd0,   24'hFF99FF, 1'b0, 1'b1};
        vt[16] = '{9'd40,  10'd419, 1'b1, 3'd0, 8'd9,   24'hFFCCE5, 1'b1, 1'b1};
        vt[17] = '{9'd100, 10'd420, 1'b1, 3'd0, 8'd0,   24'hA0A0A0, 1'b0, 1'b1};
        vt[18] = '{9'd440, 10'd220, 1'b1, 3'd0, 8'd0,   24'hA0A0A0, 1'b0, 1'b1};
        vt[19] = '{9'd439, 10'd220, 1'b1, 3'd0, 8'd190, 24'h7F00FF, 1'b1, 1'b1};
        vt[20] = '{9'd100, 10'd440, 1'b1, 3'd0, 8'd0,   24'h606060, 1'b0, 1'b1};
        vt[21] = '{9'd39,  10'd220, 1'b1, 3'd0, 8'd0,   24'hA0A0A0, 1'b0, 1'b1};

        for (int i = 0; i < 256; i++) mem[i] = 3'd0;
        mem[34]  = 3'd2;
        mem[190] = 3'd3;
        mem[199] = 3'd5;

        rst = 1'b1;
        frame_start = 1'b0;
        flash_start = 1'b0;
        flash_rows = '0;
        set_px(9'd439, 10'd220, 1'b1, 3'd0);
        repeat (3) @(negedge clk);
        chk("reset_rgb", rgb_now(), 32'h0);
        chk("reset_board", {31'd0, board}, 32'd0);
        chk("reset_busy", {31'd0, flash_busy}, 32'd0);
        chk("reset_done", {31'd0, flash_done}, 32'd0);
        rst = 1'b0;

        // A filler pixel after one cycle makes the check sensitive to exact latency.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_px(vt[i].row, vt[i].col, vt[i].blank, vt[i].nb);
            #1;
            chk($sformatf("vec%0d_addr", i), {24'd0, cell_addr}, {24'd0, vt[i].addr});
            @(negedge clk);
            set_px(9'd0, 10'd0, 1'b1, 3'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_rgb", i), rgb_now(), {8'h00, vt[i].rgb});
            if (vt[i].chk_b) chk($sformatf("vec%0d_board", i), {31'd0, board}, {31'd0, vt[i].brd});
        end

        @(negedge clk);
        set_px(9'd439, 10'd220, 1'b1, 3'd0);
        flash_rows = 20'h80000;
        flash_start = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        flash_start = 1'b0;
        frame_start = 1'b0;
        chk("flash_busy_rise", {31'd0, flash_busy}, 32'd1);
        @(negedge clk);
        chk("flash_white0", rgb_now(), 32'hFFFFFF);
        pulse_fs();
        @(negedge clk);
        chk("flash_white1", rgb_now(), 32'hFFFFFF);
        pulse_fs();
        @(negedge clk);
        chk("flash_off", rgb_now(), 32'h7F00FF);
        flash_rows = 20'hFFFFF;
        flash_start = 1'b1;
        @(negedge clk);
        flash_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_start_ignored", rgb_now(), 32'h7F00FF);
        chk("busy_hold", {31'd0, flash_busy}, 32'd1);
        pulse_fs();
        chk("done_not_yet", {31'd0, flash_done}, 32'd0);
        pulse_fs();
        chk("done_pulse", {31'd0, flash_done}, 32'd1);
        chk("busy_in_done", {31'd0, flash_busy}, 32'd1);
        @(negedge clk);
        chk("done_fall", {31'd0, flash_done}, 32'd0);
        chk("busy_fall", {31'd0, flash_busy}, 32'd0);

        flash_rows = 20'h80000;
        flash_start = 1'b1;
        @(negedge clk);
        flash_start = 1'b0;
        chk("flash2_busy", {31'd0, flash_busy}, 32'd1);
        pulse_fs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, flash_busy}, 32'd0);
        chk("rst_done", {31'd0, flash_done}, 32'd0);
        chk("rst_rgb", rgb_now(), 32'h0);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            frame_start = k[0];
            @(negedge clk);
            if (flash_done) done_seen++;
        end
        frame_start = 1'b0;
        chk("rst_no_done", done_seen, 32'd0);
        chk("rst_normal_px", rgb_now(), 32'h7F00FF);

        @(negedge clk);
        set_px(9'd439, 10'd220, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        chk("blank_in_board", rgb_now(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CELL_PX, 20, cell edge in pixels (4..64)
- BOARD_COLS, 10, playfield columns
- BOARD_ROWS, 20, playfield rows
- BOARD_X0, 220, playfield left pixel
- BOARD_Y0, 40, playfield top pixel
- NEXT_X0, 480, preview-field left pixel (field is 6x4 cells)
- NEXT_Y0, 40, preview-field top pixel
- FRAME_PX, 20, frame thickness around both fields
- FLASH_FRAMES, 8, frames per flash phase
- FLASH_BLINKS, 3, on/off blink pairs per flash
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- blank_n, in, 1, active video
- row, in, 9, current pixel row
- column, in, 10, current pixel column
- frame_start, in, 1, one-cycle pulse per frame
- next_block, in, 3, preview piece type
- cell_addr, out, AW=$clog2(BOARD_COLS*BOARD_ROWS), board memory address, combinational
- cell_data, in, 3, cell type (0 = empty); synchronous read, valid one cycle after cell_addr
- flash_start, in, 1, start line-clear flash
- flash_rows, in, BOARD_ROWS, row mask, sampled on accepted flash_start
- flash_busy, out, 1, flash in progress
- flash_done, out, 1, one-cycle completion pulse
- board, out, 1, pixel is inside playfield, pipeline-aligned
- red, out, 8, red channel, registered
- green, out, 8, green channel, registered
- blue, out, 8, blue channel, registered

Function
REQ-004 Playfield: column in [BOARD_X0, BOARD_X0+BOARD_COLS*CELL_PX) and row in [BOARD_Y0, BOARD_Y0+BOARD_ROWS*CELL_PX).
REQ-005 cell_addr = cell_row*BOARD_COLS + cell_col, where cell_row and cell_col are pixel offset divided by CELL_PX; cell_addr is 0 outside the playfield.
REQ-006 Frame: a FRAME_PX-wide ring surrounding each field; the preview field is 6*CELL_PX x 4*CELL_PX.
REQ-007 Latency is exactly 2 clocks from row/column/blank_n to red/green/blue/board. Stage 1 registers the region code, cell_row and blank_n. Stage 2 combines these with cell_data and registers the colour.
REQ-008 Colour priority: blank_n low gives 0. Otherwise:
- playfield: flash colour, else cell colour
- frame: LIGHT_GREY (160,160,160)
- preview: piece colour, else PURPLE (255,153,255)
- elsewhere: DARK_GREY (96,96,96)
REQ-009 Cell colours:
- 0: LIGHT_ROSE (255,204,229)
- 7 (I): MINTY (153,255,204)
- 1 (T): BLUE (102,178,255)
- 2 (O): PINK (255,51,153)
- 3 (L): DARK_PURPLE (127,0,255)
- 4 (J): YELLOW (255,255,102)
- 5 (S): GREEN (102,255,102)
- 6 (Z): PLUM (153,0,153)
REQ-010 Preview shapes (grid row,col), 6x4 grid:
- I: r1 c1-4
- T: r1 c1-3, r2 c2
- O: r1-2 c2-3
- L: r2 c1-3, r1 c3
- J: r1 c1-3, r2 c1
- S: r1 c2-3, r2 c1-2
- Z: r1 c1-2, r2 c2-3
- next_block=0: field all PURPLE
REQ-011 Flash FSM states: IDLE, FLASH, DONE.
- IDLE, flash_start=1: latch flash_rows, clear counters, phase=1, go to FLASH.
- FLASH: count frame_start pulses; at the FLASH_FRAMES-th pulse, toggle phase and clear the count.
- After 2*FLASH_BLINKS toggles, go to DONE.
- DONE: flash_done=1 for one cycle, clear the mask, then IDLE.
REQ-012 flash_busy is 1 in FLASH and DONE. A flash_start while busy is ignored. A frame_start in the same cycle as an accepted flash_start is not counted.
REQ-013 In FLASH with phase=1, playfield pixels in masked rows are WHITE (255,255,255), whatever their cell_data. The mask is indexed by the stage-1 cell_row.

Reset
REQ-014 rst=1 at a clock edge has these effects:
- red/green/blue=0, board=0
- pipeline flags cleared
- FSM to IDLE, mask, phase and counters cleared
- flash_busy=0, flash_done=0
- This applies mid-flash too; no flash_done pulse is issued.
REQ-015 Outputs are valid 2 clocks after rst deasserts.

Configuration
REQ-016 Macro BOARD_RENDERER_GRID_EN.
- Defined: playfield pixels with in-cell x or y offset equal to 0 render DARK_GREY. This overrides cell colour but not flash WHITE.
- Undefined: no grid lines; cells are solid.

Verification
REQ-017 Directed scenarios:
- Latency: default parameters, row=40, column=220, blank_n=1, cell_data=0 returned next cycle -> cell_addr=0; 2 clocks later rgb=(255,204,229) and board=1.
- Addressing: row=439, column=419 -> cell_addr=199. Then row=100, column=300 -> cell_addr=34 (cell_row 3, cell_col 4). With cell_data=2 returned -> rgb=(255,51,153).
- Preview: next_block=7, row=70, column=520 (grid r1 c2) -> rgb=(153,255,204). Same pixel with next_block=0 -> (255,153,255). Pixel at row=30, column=210 -> (160,160,160).
- Flash: flash_rows bit 19 set, flash_start, FLASH_FRAMES=2, FLASH_BLINKS=1 -> row 19 cells are WHITE for 2 frames, then normal for 2 frames. flash_done pulses at the 4th frame_start; flash_busy falls the cycle after.
- Boundaries: flash_start while busy -> ignored. rst during FLASH -> flash_busy=0 next cycle, no flash_done. blank_n=0 inside the playfield -> rgb=0 two clocks later.
